// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter
//   Shares one i2c_master command / write-data / read-data interface between
//   NUM_REQ requesters. Ownership is granted round-robin and lasts a whole I2C
//   transaction: from the first command, through the command carrying stop,
//   until the master has been seen idle for two consecutive cycles.
//
//   Optional feature: define ARB_FORCE_STOP_EN to enable the hold timer. An
//   owner that stays silent for HOLD_TIMEOUT cycles gets a stop command
//   injected on its behalf, and req_timeout pulses for it.
//
// Ports
//   clk, rst               clock, synchronous active-low reset
//   req_cmd_*              per-requester command streams (address slice i*7)
//   req_wr_*               per-requester write-data streams (data slice i*8)
//   req_rd_*               read data broadcast, per-requester valid/last/ready
//   req_missed_ack         registered missed-ack pulse steered to the owner
//   req_timeout            forced-stop pulse (tied 0 without the macro)
//   grant                  registered one-hot owner
//   m_cmd_* / m_wr_* / m_rd_*  single i2c_master side
//   mst_busy, mst_missed_ack   master status
module i2c_master_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ*7-1:0] req_cmd_address,
  input  logic [NUM_REQ-1:0]   req_cmd_start,
  input  logic [NUM_REQ-1:0]   req_cmd_read,
  input  logic [NUM_REQ-1:0]   req_cmd_write,
  input  logic [NUM_REQ-1:0]   req_cmd_write_multiple,
  input  logic [NUM_REQ-1:0]   req_cmd_stop,
  input  logic [NUM_REQ-1:0]   req_cmd_valid,
  output logic [NUM_REQ-1:0]   req_cmd_ready,
  input  logic [NUM_REQ*8-1:0] req_wr_tdata,
  input  logic [NUM_REQ-1:0]   req_wr_tvalid,
  input  logic [NUM_REQ-1:0]   req_wr_tlast,
  output logic [NUM_REQ-1:0]   req_wr_tready,
  output logic [7:0]           req_rd_tdata,
  output logic [NUM_REQ-1:0]   req_rd_tvalid,
  output logic [NUM_REQ-1:0]   req_rd_tlast,
  input  logic [NUM_REQ-1:0]   req_rd_tready,
  output logic [NUM_REQ-1:0]   req_missed_ack,
  output logic [NUM_REQ-1:0]   req_timeout,
  output logic [NUM_REQ-1:0]   grant,
  output logic [6:0]           m_cmd_address,
  output logic                 m_cmd_start,
  output logic                 m_cmd_read,
  output logic                 m_cmd_write,
  output logic                 m_cmd_write_multiple,
  output logic                 m_cmd_stop,
  output logic                 m_cmd_valid,
  input  logic                 m_cmd_ready,
  output logic [7:0]           m_wr_tdata,
  output logic                 m_wr_tvalid,
  output logic                 m_wr_tlast,
  input  logic                 m_wr_tready,
  input  logic [7:0]           m_rd_tdata,
  input  logic                 m_rd_tvalid,
  input  logic                 m_rd_tlast,
  output logic                 m_rd_tready,
  input  logic                 mst_busy,
  input  logic                 mst_missed_ack
);

  localparam int IW = $clog2(NUM_REQ);

`ifdef ARB_FORCE_STOP_EN
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN, S_FSTOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN} state_t;
`endif

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        ptr_q, ptr_d;     // owner index while granted, last owner otherwise
  logic                 dcnt_q, dcnt_d;   // one idle sample already seen in DRAIN
  logic [NUM_REQ-1:0]   miss_q, miss_d;
  logic [NUM_REQ-1:0]   to_q, to_d;
`ifdef ARB_FORCE_STOP_EN
  logic [15:0]          hold_q, hold_d;
`endif

  // per-requester views of the packed buses
  logic [NUM_REQ-1:0][6:0] addr_v;
  logic [NUM_REQ-1:0][7:0] wdat_v;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign addr_v[i] = req_cmd_address[i*7 +: 7];
    assign wdat_v[i] = req_wr_tdata[i*8 +: 8];
  end

  assign req_rd_tdata   = m_rd_tdata;
  assign grant          = grant_q;
  assign req_missed_ack = miss_q;
  assign req_timeout    = to_q;

  always_comb begin
    int  idx;
    logic found;
    idx                  = 0;
    found                = 1'b0;
    state_d              = state_q;
    grant_d              = grant_q;
    ptr_d                = ptr_q;
    dcnt_d               = dcnt_q;
    to_d                 = '0;
    miss_d               = mst_missed_ack ? (NUM_REQ'(1) << ptr_q) : '0;
`ifdef ARB_FORCE_STOP_EN
    hold_d               = hold_q;
`endif
    req_cmd_ready        = '0;
    m_cmd_address        = '0;
    m_cmd_start          = 1'b0;
    m_cmd_read           = 1'b0;
    m_cmd_write          = 1'b0;
    m_cmd_write_multiple = 1'b0;
    m_cmd_stop           = 1'b0;
    m_cmd_valid          = 1'b0;
    m_wr_tdata           = '0;
    m_wr_tvalid          = 1'b0;
    m_wr_tlast           = 1'b0;
    req_wr_tready        = '0;
    m_rd_tready          = 1'b0;
    req_rd_tvalid        = '0;
    req_rd_tlast         = '0;

    // data paths stay with the owner for the whole ownership, including DRAIN
    if (state_q != S_IDLE) begin
      m_wr_tdata           = wdat_v[ptr_q];
      m_wr_tvalid          = req_wr_tvalid[ptr_q];
      m_wr_tlast           = req_wr_tlast[ptr_q];
      req_wr_tready[ptr_q] = m_wr_tready;
      m_rd_tready          = req_rd_tready[ptr_q];
      req_rd_tvalid[ptr_q] = m_rd_tvalid;
      req_rd_tlast[ptr_q]  = m_rd_tlast;
    end

    case (state_q)
      S_IDLE: begin
        // round-robin: first valid requester after the last owner, with wrap
        for (int k = 1; k <= NUM_REQ; k++) begin
          idx = int'(ptr_q) + k;
          if (idx >= NUM_REQ) idx = idx - NUM_REQ;
          if (!found && req_cmd_valid[idx]) begin
            found   = 1'b1;
            ptr_d   = IW'(idx);
            grant_d = NUM_REQ'(1) << idx;
            state_d = S_GRANT;
          end
        end
`ifdef ARB_FORCE_STOP_EN
        hold_d = '0;
`endif
      end
      S_GRANT: begin
        m_cmd_address        = addr_v[ptr_q];
        m_cmd_start          = req_cmd_start[ptr_q];
        m_cmd_read           = req_cmd_read[ptr_q];
        m_cmd_write          = req_cmd_write[ptr_q];
        m_cmd_write_multiple = req_cmd_write_multiple[ptr_q];
        m_cmd_stop           = req_cmd_stop[ptr_q];
        m_cmd_valid          = req_cmd_valid[ptr_q];
        req_cmd_ready[ptr_q] = m_cmd_ready;
        if (m_cmd_valid && m_cmd_ready && m_cmd_stop) begin
          state_d = S_DRAIN;
          dcnt_d  = 1'b0;
        end
`ifdef ARB_FORCE_STOP_EN
        else if ((m_cmd_valid && m_cmd_ready) || (m_wr_tvalid && m_wr_tready)) begin
          hold_d = '0;
        end else if (hold_q == 16'(HOLD_TIMEOUT - 1)) begin
          hold_d  = '0;
          state_d = S_FSTOP;
        end else begin
          hold_d = hold_q + 16'd1;
        end
`endif
      end
      S_DRAIN: begin
        // two consecutive idle samples tolerate busy rising late
        if (!mst_busy) begin
          if (dcnt_q) begin
            state_d = S_IDLE;
            grant_d = '0;
            dcnt_d  = 1'b0;
          end else begin
            dcnt_d = 1'b1;
          end
        end else begin
          dcnt_d = 1'b0;
        end
      end
`ifdef ARB_FORCE_STOP_EN
      S_FSTOP: begin
        m_cmd_stop  = 1'b1;
        m_cmd_valid = 1'b1;
        if (m_cmd_ready) begin
          to_d[ptr_q] = 1'b1;
          state_d     = S_DRAIN;
          dcnt_d      = 1'b0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
      dcnt_q  <= 1'b0;
      miss_q  <= '0;
      to_q    <= '0;
`ifdef ARB_FORCE_STOP_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      dcnt_q  <= dcnt_d;
      miss_q  <= miss_d;
      to_q    <= to_d;
`ifdef ARB_FORCE_STOP_EN
      hold_q  <= hold_d;
`endif
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter (NUM_REQ=2). The bench plays both the
// requesters and the i2c_master. Inputs change 1ns after posedge; outputs are
// checked 1ns after that.
module tb_i2c_master_arbiter;
  localparam int N = 2;
`ifdef ARB_FORCE_STOP_EN
  localparam int HT = 16;
`else
  localparam int HT = 1024;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic [N*7-1:0] req_cmd_address = '0;
  logic [N-1:0] req_cmd_start = '0, req_cmd_read = '0, req_cmd_write = '0;
  logic [N-1:0] req_cmd_write_multiple = '0, req_cmd_stop = '0, req_cmd_valid = '0;
  logic [N-1:0] req_cmd_ready;
  logic [N*8-1:0] req_wr_tdata = '0;
  logic [N-1:0] req_wr_tvalid = '0, req_wr_tlast = '0, req_wr_tready;
  logic [7:0] req_rd_tdata;
  logic [N-1:0] req_rd_tvalid, req_rd_tlast, req_rd_tready = '0;
  logic [N-1:0] req_missed_ack, req_timeout, grant;
  logic [6:0] m_cmd_address;
  logic m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop, m_cmd_valid;
  logic m_cmd_ready = 1'b0;
  logic [7:0] m_wr_tdata;
  logic m_wr_tvalid, m_wr_tlast, m_wr_tready = 1'b0;
  logic [7:0] m_rd_tdata = '0;
  logic m_rd_tvalid = 1'b0, m_rd_tlast = 1'b0, m_rd_tready;
  logic mst_busy = 1'b0, mst_missed_ack = 1'b0;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  i2c_master_arbiter #(.NUM_REQ(N), .HOLD_TIMEOUT(HT)) dut (
    .clk(clk), .rst(rst),
    .req_cmd_address(req_cmd_address), .req_cmd_start(req_cmd_start),
    .req_cmd_read(req_cmd_read), .req_cmd_write(req_cmd_write),
    .req_cmd_write_multiple(req_cmd_write_multiple), .req_cmd_stop(req_cmd_stop),
    .req_cmd_valid(req_cmd_valid), .req_cmd_ready(req_cmd_ready),
    .req_wr_tdata(req_wr_tdata), .req_wr_tvalid(req_wr_tvalid),
    .req_wr_tlast(req_wr_tlast), .req_wr_tready(req_wr_tready),
    .req_rd_tdata(req_rd_tdata), .req_rd_tvalid(req_rd_tvalid),
    .req_rd_tlast(req_rd_tlast), .req_rd_tready(req_rd_tready),
    .req_missed_ack(req_missed_ack), .req_timeout(req_timeout), .grant(grant),
    .m_cmd_address(m_cmd_address), .m_cmd_start(m_cmd_start), .m_cmd_read(m_cmd_read),
    .m_cmd_write(m_cmd_write), .m_cmd_write_multiple(m_cmd_write_multiple),
    .m_cmd_stop(m_cmd_stop), .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_wr_tdata(m_wr_tdata), .m_wr_tvalid(m_wr_tvalid), .m_wr_tlast(m_wr_tlast),
    .m_wr_tready(m_wr_tready), .m_rd_tdata(m_rd_tdata), .m_rd_tvalid(m_rd_tvalid),
    .m_rd_tlast(m_rd_tlast), .m_rd_tready(m_rd_tready),
    .mst_busy(mst_busy), .mst_missed_ack(mst_missed_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one cycle; inputs may then be changed, then settle()
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic settle();
    #1;
  endtask

  task automatic set_cmd(input int r, input logic [6:0] a, input logic st, input logic rd,
                         input logic wr, input logic wm, input logic sp, input logic v);
    req_cmd_address[r*7 +: 7] = a;
    req_cmd_start[r] = st; req_cmd_read[r] = rd; req_cmd_write[r] = wr;
    req_cmd_write_multiple[r] = wm; req_cmd_stop[r] = sp; req_cmd_valid[r] = v;
  endtask

  task automatic do_reset();
    rst = 1'b0; req_cmd_valid = '0; req_wr_tvalid = '0; m_rd_tvalid = 1'b0;
    mst_busy = 1'b0; mst_missed_ack = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  initial begin
    logic [N-1:0] seq [4];
    logic [N-1:0] prev;
    int nrec, to_cnt, rdy1_cnt;

    // ---- reset state
    tick(); tick(); settle();
    chk("rst_grant", grant, 0);
    chk("rst_cmd_ready", req_cmd_ready, 0);
    chk("rst_m_cmd_valid", m_cmd_valid, 0);
    chk("rst_missed_ack", req_missed_ack, 0);
    chk("rst_timeout", req_timeout, 0);
    rst = 1'b1;

    // ---- 1: write_multiple to 0x22 with three bytes
    set_cmd(0, 7'h22, 1, 0, 0, 1, 1, 1);
    settle();
    chk("t1_idle_grant", grant, 0);
    chk("t1_idle_m_valid", m_cmd_valid, 0);
    tick(); settle();
    chk("t1_grant", grant, 2'b01);
    chk("t1_m_addr", m_cmd_address, 7'h22);
    chk("t1_m_flags", {m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop, m_cmd_valid}, 6'b100111);
    req_wr_tdata[7:0] = 8'hA1; req_wr_tvalid[0] = 1'b1; m_wr_tready = 1'b1; m_cmd_ready = 1'b1;
    settle();
    chk("t1_cmd_ready", req_cmd_ready, 2'b01);
    chk("t1_wr_a1", {m_wr_tvalid, m_wr_tdata}, 9'h1A1);
    chk("t1_wr_ready", req_wr_tready, 2'b01);
    tick();
    req_cmd_valid[0] = 1'b0; req_wr_tdata[7:0] = 8'hA2; mst_busy = 1'b1; settle();
    chk("t1_drain_m_valid", m_cmd_valid, 0);
    chk("t1_drain_cmd_ready", req_cmd_ready, 0);
    chk("t1_wr_a2", {m_wr_tvalid, m_wr_tlast, m_wr_tdata}, 10'h0A2 | 10'h200);
    tick();
    req_wr_tdata[7:0] = 8'hA3; req_wr_tlast[0] = 1'b1; settle();
    chk("t1_wr_a3", {m_wr_tvalid, m_wr_tlast, m_wr_tdata}, 10'h3A3);
    tick();
    req_wr_tvalid[0] = 1'b0; req_wr_tlast[0] = 1'b0;
    tick();
    mst_busy = 1'b0; settle();
    chk("t1_busy_fell", grant, 2'b01);
    tick(); settle();
    chk("t1_busy_fell_p1", grant, 2'b01);
    tick(); settle();
    chk("t1_busy_fell_p2", grant, 2'b00);

    // ---- 2: round robin, both requesting continuously
    do_reset();
    m_cmd_ready = 1'b1;
    set_cmd(0, 7'h10, 1, 0, 1, 0, 1, 1);
    set_cmd(1, 7'h11, 1, 0, 1, 0, 1, 1);
    prev = '0; nrec = 0;
    for (int c = 0; c < 40 && nrec < 4; c++) begin
      settle();
      if (grant != 0 && prev == 0) begin
        seq[nrec] = grant;
        chk("t2_addr", m_cmd_address, grant == 2'b01 ? 7'h10 : 7'h11);
        nrec++;
      end
      prev = grant;
      tick();
    end
    chk("t2_nrec", nrec, 4);
    chk("t2_seq", {seq[0], seq[1], seq[2], seq[3]}, 8'b01_10_01_10);
    req_cmd_valid = '0;

    // ---- 3: two-command transaction while req1 waits
    do_reset();
    m_cmd_ready = 1'b1;
    set_cmd(0, 7'h37, 1, 0, 1, 0, 0, 1);
    set_cmd(1, 7'h44, 1, 0, 1, 0, 1, 1);
    settle();
    chk("t3_idle_ready", req_cmd_ready, 0);
    tick(); settle();
    chk("t3_grant0", grant, 2'b01);
    chk("t3_ready0", req_cmd_ready, 2'b01);
    tick();
    set_cmd(0, 7'h37, 0, 1, 0, 0, 1, 1); settle();
    chk("t3_ready_rd", req_cmd_ready, 2'b01);
    chk("t3_m_read_stop", {m_cmd_read, m_cmd_stop, m_cmd_address}, {2'b11, 7'h37});
    tick();
    req_cmd_valid[0] = 1'b0; settle();
    chk("t3_drain_ready_a", req_cmd_ready, 0);
    tick(); settle();
    chk("t3_drain_ready_b", req_cmd_ready, 0);
    tick(); settle();
    chk("t3_idle_bubble", grant, 0);
    tick(); settle();
    chk("t3_grant1", grant, 2'b10);
    chk("t3_ready1", req_cmd_ready, 2'b10);
    chk("t3_addr1", m_cmd_address, 7'h44);
    req_cmd_valid = '0;

    // ---- 4: req1 reads two bytes, master reports missed ack
    do_reset();
    m_cmd_ready = 1'b1;
    set_cmd(1, 7'h2a, 1, 1, 0, 0, 1, 1);
    tick(); settle();
    chk("t4_grant", grant, 2'b10);
    tick();
    req_cmd_valid = '0; mst_busy = 1'b1; req_rd_tready = 2'b11;
    m_rd_tdata = 8'h5C; m_rd_tvalid = 1'b1; m_rd_tlast = 1'b0; mst_missed_ack = 1'b1;
    settle();
    chk("t4_rd0", {req_rd_tvalid, req_rd_tlast, req_rd_tdata}, {2'b10, 2'b00, 8'h5C});
    chk("t4_m_rd_tready", m_rd_tready, 1);
    tick();
    m_rd_tdata = 8'h3D; m_rd_tlast = 1'b1; mst_missed_ack = 1'b0; settle();
    chk("t4_rd1", {req_rd_tvalid, req_rd_tlast, req_rd_tdata}, {2'b10, 2'b10, 8'h3D});
    chk("t4_missed_ack", req_missed_ack, 2'b10);
    tick();
    m_rd_tvalid = 1'b0; m_rd_tlast = 1'b0; mst_busy = 1'b0; req_rd_tready = '0; settle();
    chk("t4_missed_ack_gone", req_missed_ack, 0);
    tick(); tick(); settle();
    chk("t4_released", grant, 0);

    // ---- 5: reset while req1 owns
    do_reset();
    m_cmd_ready = 1'b0;
    set_cmd(1, 7'h05, 1, 0, 1, 0, 0, 1);
    tick(); settle();
    chk("t5_grant1", grant, 2'b10);
    req_cmd_valid[0] = 1'b1;
    rst = 1'b0;
    tick(); settle();
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_m_valid", m_cmd_valid, 0);
    rst = 1'b1;
    tick(); settle();
    chk("t5_req0_wins", grant, 2'b01);
    req_cmd_valid = '0;

    // ---- 6: owner goes silent after start+write
    do_reset();
    m_cmd_ready = 1'b1;
    set_cmd(0, 7'h50, 1, 0, 1, 0, 0, 1);
    tick(); settle();
    chk("t6_grant", grant, 2'b01);
    tick();
    req_cmd_valid[0] = 1'b0;
    set_cmd(1, 7'h51, 1, 0, 1, 0, 1, 1);
    to_cnt = 0; rdy1_cnt = 0;
`ifdef ARB_FORCE_STOP_EN
    begin
      int saw_stop, saw_rel;
      saw_stop = 0; saw_rel = 0;
      for (int c = 0; c < 100; c++) begin
        settle();
        if (grant == 2'b01 && m_cmd_valid && m_cmd_stop && !m_cmd_start && !m_cmd_write && m_cmd_address == 0)
          saw_stop++;
        if (req_timeout != 0) begin
          to_cnt++;
          chk("t6_timeout_vec", req_timeout, 2'b01);
        end
        if (grant == 0) saw_rel = 1;
        tick();
      end
      chk("t6_forced_stop", saw_stop != 0, 1);
      chk("t6_timeout_pulses", to_cnt, 1);
      chk("t6_released", saw_rel, 1);
    end
`else
    for (int c = 0; c < 1100; c++) begin
      settle();
      if (req_timeout != 0) to_cnt++;
      if (req_cmd_ready[1]) rdy1_cnt++;
      tick();
    end
    settle();
    chk("t6_held", grant, 2'b01);
    chk("t6_no_timeout", to_cnt, 0);
    chk("t6_req1_blocked", rdy1_cnt, 0);
`endif
    req_cmd_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
